// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states, operand width and default iteration count.
package mdu_pkg;

  localparam int XLEN      = 32;
  localparam int ITERS_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic op_signed(input logic [1:0] o);
    return !o[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational abs/negate helper: operand magnitudes in, sign-fixed results out.
// Ports: a,b,sgn -> mag_a,mag_b ; raw,is_mul,neg_q,neg_r -> res_hi,res_lo.
module mdu_sign_fix
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              sgn,
  input  logic [2*XLEN-1:0] raw,
  input  logic              is_mul,
  input  logic              neg_q,
  input  logic              neg_r,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic [XLEN-1:0]   res_hi,
  output logic [XLEN-1:0]   res_lo
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;

  always_comb begin
    mag_a = (sgn && a[XLEN-1]) ? -a : a;
    mag_b = (sgn && b[XLEN-1]) ? -b : b;
    prod  = neg_q ? -raw : raw;
    // divide layout: remainder in the upper half, quotient in the lower
    rem   = raw[2*XLEN-1:XLEN];
    quo   = raw[XLEN-1:0];
    if (is_mul) begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end else begin
      res_hi = neg_r ? -rem : rem;
      res_lo = neg_q ? -quo : quo;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: start/op/operand_a/operand_b issue, hi_we/lo_we/wdata MTHI/MTLO,
// busy/done/div_by_zero status, hi/lo results.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int ITERS = ITERS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITERS + 1);

  state_e            state;
  state_e            state_nx;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] work;
  logic [2*XLEN-1:0] work_nx;
  logic [XLEN-1:0]   dvsr;
  logic              div_q;
  logic              neg_q;
  logic              neg_r;
  logic              dbz;

  logic              accept;
  logic              in_div;
  logic              b_zero;
  logic              last;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rsh;
  logic [XLEN:0]     diff;

  assign accept = start && (state != S_CALC);
  assign in_div = op_is_div(op);
  assign b_zero = (operand_b == '0);
  assign last   = (cnt == CW'(ITERS));

  mdu_sign_fix u_fix (
    .a      (operand_a),
    .b      (operand_b),
    .sgn    (op_signed(op)),
    .raw    (work),
    .is_mul (!div_q),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // One iteration step. Multiply: add multiplicand into the upper half
  // when the multiplier LSB is set, then shift right. Divide: shift the
  // next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    sum  = {1'b0, work[2*XLEN-1:XLEN]}
         + (work[0] ? {1'b0, dvsr} : '0);
    rsh  = {work[2*XLEN-1:XLEN], work[XLEN-1]};
    diff = rsh - {1'b0, dvsr};
    if (!div_q) begin
      work_nx = {sum, work[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      work_nx = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
    end else begin
      work_nx = {rsh[XLEN-1:0], work[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = (in_div && b_zero) ? S_DONE : S_CALC;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CALC: begin
        if (last) begin
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_CALC);
    done        = (state == S_DONE);
    div_by_zero = (state == S_DONE) && dbz;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      work  <= '0;
      dvsr  <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (accept) begin
      cnt   <= '0;
      work  <= {{XLEN{1'b0}}, mag_a};
      dvsr  <= mag_b;
      div_q <= in_div;
      neg_q <= op_signed(op) && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
      neg_r <= op_signed(op) && in_div && operand_a[XLEN-1];
      dbz   <= in_div && b_zero;
    end else if (state == S_CALC) begin
      if (!last) begin
        work <= work_nx;
        cnt  <= cnt + CW'(1);
      end else begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (hi_we) begin
        hi <= wdata;
      end
      if (lo_we) begin
        lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit against a plain-arithmetic
// reference model of HI/LO; a negedge monitor checks every done pulse.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mul_div_unit #(.ITERS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (a),
    .operand_b   (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic [31:0] ohi,
                                 input logic [31:0] olo);
    exp_t   e;
    longint sx;
    longint sy;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.hi = ohi;
    e.lo = olo;
    e.dbz = 1'b0;
    case (o)
      2'b00: begin
        p = sx * sy;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b10: begin
        if (y == 0) begin
          e.dbz = 1'b1;
        end else begin
          q = sx / sy;
          r = sx % sy;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: begin
        if (y == 0) begin
          e.dbz = 1'b1;
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 want no pending op");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_dbz", {31'b0, dbz}, {31'b0, e.dbz});
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke,
                        input bit we_start);
    exp_t        e;
    logic [31:0] old_hi;
    int          k;
    int          nb;
    int          want;
    e = model(o, x, y, m_hi, m_lo);
    old_hi = m_hi;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (we_start) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = $urandom;
    end
    sbq.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    want = (o[1] && y == 0) ? 0 : 33;
    k = 0;
    nb = 0;
    while (!done && k < 200) begin
      if (busy) nb++;
      if (k == poke) begin
        start = 1'b1;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        hi_we = 1'b1;
        wdata = 32'hABCD;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
      end
      @(negedge clk);
      k++;
      if (k == poke + 1) check("hi_in_calc", hi, old_hi);
    end
    start = 1'b0;
    hi_we = 1'b0;
    check("latency", k, want);
    if (want != 0) check("busy_cycles", nb, 33);
  endtask

  task automatic mt(input bit sel_hi, input logic [31:0] d);
    hi_we = sel_hi;
    lo_we = !sel_hi;
    wdata = d;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (sel_hi) begin
      m_hi = d;
      check("mthi", hi, d);
    end else begin
      m_lo = d;
      check("mtlo", lo, d);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_dbz", {31'b0, dbz}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    @(negedge clk);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(negedge clk);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5, 1'b0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    @(negedge clk);
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    run_op(2'b11, 32'd100, 32'd0, -1, 1'b0);
    check("dbz_flag", {31'b0, dbz}, 32'h1);
    check("dbz_hi", hi, 32'h11);
    check("dbz_lo", lo, 32'h22);
    @(negedge clk);
    run_op(2'b11, 32'd100, 32'd7, 10, 1'b0);
    @(negedge clk);
    mt(1'b1, 32'hABCD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);
    check("ovf_dbz", {31'b0, dbz}, 32'h0);

    @(negedge clk);
    start = 1'b1;
    op = 2'b11;
    a = 32'd100;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    run_op(2'b11, 32'd100, 32'd7, -1, 1'b0);
    check("rerun_lo", lo, 32'd14);
    check("rerun_hi", hi, 32'd2);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      o = 2'($urandom);
      x = pick();
      y = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        mt(1'($urandom), $urandom);
      end
      run_op(o, x, y,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1,
             1'($urandom));
    end
    @(negedge clk);
    check("sb_empty", sbq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
